// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage with an 8x8 register file and per-register busy scoreboard
// feeding a registered valid/ready EX slot. Optional macro WB_BYPASS_EN forwards same-cycle writeback data.
module alu_issue_stage #(
    parameter int unsigned       DATA_W   = 8,
    parameter logic [DATA_W-1:0] REG_INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_rd,
    input  logic              wb_en,
    input  logic [2:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              illegal
);

    localparam logic [3:0] OP_LI = 4'b1000;

    logic [3:0]        op_s;
    logic [2:0]        rd_s;
    logic [2:0]        rs1_s;
    logic [2:0]        rs2_s;
    logic [DATA_W-1:0] imm_s;
    logic              is_alu_s;
    logic              is_li_s;
    logic              is_legal_s;
    logic              hazard_s;
    logic              accept_s;
    logic              load_s;
    logic [7:0]        wb_mask_s;
    logic [7:0]        flush_mask_s;
    logic [7:0]        set_mask_s;
    logic [7:0]        busy_eff_s;
    logic [DATA_W-1:0] src_a_s;
    logic [DATA_W-1:0] src_b_s;

    logic [DATA_W-1:0] rf_q [0:7];
    logic [7:0]        busy_q;
    logic [7:0]        busy_d;
    logic              out_valid_q;
    logic              illegal_q;
    logic [3:0]        out_opcode_q;
    logic [3:0]        opcode_d;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;
    logic [2:0]        out_rd_q;

    assign op_s       = in_instr[15:12];
    assign rd_s       = in_instr[11:9];
    assign rs1_s      = in_instr[8:6];
    assign rs2_s      = in_instr[5:3];
    assign imm_s      = in_instr[DATA_W-1:0];
    assign is_alu_s   = (op_s[3] == 1'b0);
    assign is_li_s    = (op_s == OP_LI);
    assign is_legal_s = is_alu_s || is_li_s;

    // One-hot view of the register being written back this cycle.
    always_comb begin
        wb_mask_s = 8'h00;
        if (wb_en) begin
            wb_mask_s[wb_rd] = 1'b1;
        end else begin
            wb_mask_s = 8'h00;
        end
    end

`ifdef WB_BYPASS_EN
    assign busy_eff_s = busy_q & ~wb_mask_s;
`else
    assign busy_eff_s = busy_q;
`endif

    // LI ignores its rs fields (they alias the immediate); rd is checked for every legal op.
    assign hazard_s = is_legal_s &&
                      ((is_alu_s && (busy_eff_s[rs1_s] || busy_eff_s[rs2_s])) || busy_eff_s[rd_s]);
    assign in_ready = !flush && (!out_valid_q || out_ready) && !hazard_s;
    assign accept_s = in_valid && in_ready;
    assign load_s   = accept_s && is_legal_s;

    // Scoreboard set/clear masks for the flushed slot and the newly issued destination.
    always_comb begin
        flush_mask_s = 8'h00;
        set_mask_s   = 8'h00;
        if (flush && out_valid_q) begin
            flush_mask_s[out_rd_q] = 1'b1;
        end else begin
            flush_mask_s = 8'h00;
        end
        if (load_s && (rd_s != 3'd0)) begin
            set_mask_s[rd_s] = 1'b1;
        end else begin
            set_mask_s = 8'h00;
        end
    end

    // Set is ORed in last so an issue beats a same-cycle clear; r0 never becomes busy.
    assign busy_d = ((busy_q & ~wb_mask_s & ~flush_mask_s) | set_mask_s) & 8'hFE;

    // Register-file read, with optional same-cycle writeback forwarding; rf_q[0] stays zero.
    always_comb begin
        src_a_s = rf_q[rs1_s];
        src_b_s = rf_q[rs2_s];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_rd == rs1_s) && (rs1_s != 3'd0)) begin
            src_a_s = wb_data;
        end else begin
            src_a_s = rf_q[rs1_s];
        end
        if (wb_en && (wb_rd == rs2_s) && (rs2_s != 3'd0)) begin
            src_b_s = wb_data;
        end else begin
            src_b_s = rf_q[rs2_s];
        end
`endif
    end

    // Slot contents for the instruction being decoded.
    always_comb begin
        opcode_d = 4'b0000;
        a_d      = {DATA_W{1'b0}};
        b_d      = {DATA_W{1'b0}};
        if (is_li_s) begin
            opcode_d = 4'b0000;
            a_d      = {DATA_W{1'b0}};
            b_d      = imm_s;
        end else begin
            opcode_d = op_s;
            a_d      = src_a_s;
            b_d      = src_b_s;
        end
    end

    // Register file write port driven by WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q[0] <= {DATA_W{1'b0}};
            for (int i = 1; i < 8; i++) begin
                rf_q[i] <= REG_INIT;
            end
        end else if (wb_en && (wb_rd != 3'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Busy scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 8'h00;
        end else begin
            busy_q <= busy_d;
        end
    end

    // EX slot and illegal-op pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_opcode_q <= 4'b0000;
            out_a_q      <= {DATA_W{1'b0}};
            out_b_q      <= {DATA_W{1'b0}};
            out_rd_q     <= 3'd0;
            illegal_q    <= 1'b0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (load_s) begin
                out_valid_q  <= 1'b1;
                out_opcode_q <= opcode_d;
                out_a_q      <= a_d;
                out_b_q      <= b_d;
                out_rd_q     <= rd_s;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            illegal_q <= accept_s && !is_legal_s;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_opcode = out_opcode_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_rd     = out_rd_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run against an
// architectural reference model (register array, pending-write set, one-entry slot).
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [2:0]  out_rd;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        flush;
    logic        illegal;

    int vectors     = 0;
    int miscompares = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wb_en    = 1'b0;
        wb_rd    = 3'd0;
        wb_data  = 8'h00;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_instr  = 16'h0000;
        out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd, illegal} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd, illegal}, 25'd0);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b exp %b", in_ready, 1'b1);
        end
        tick();
        // r5 and r7 hold their reset value
        in_instr = mk(4'h0, 3'd0, 3'd5, 3'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h0, 8'h00, 8'h00, 3'd0}) begin
            miscompares++;
            $display("FAIL reg_init got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h0, 8'h00, 8'h00, 3'd0});
        end
    endtask

    task automatic test_add_li();
        wb_en = 1'b1; wb_rd = 3'd1; wb_data = 8'h05;
        tick();
        wb_rd = 3'd2; wb_data = 8'h03;
        tick();
        wb_en = 1'b0;
        in_instr = 16'h0650;
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL add_ready got %b exp %b", in_ready, 1'b1);
        end
        tick();
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h0, 8'h05, 8'h03, 3'd3}) begin
            miscompares++;
            $display("FAIL add_slot got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h0, 8'h05, 8'h03, 3'd3});
        end
        in_instr = 16'h88A5;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h0, 8'h00, 8'hA5, 3'd4}) begin
            miscompares++;
            $display("FAIL li_slot got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h0, 8'h00, 8'hA5, 3'd4});
        end
    endtask

    task automatic test_raw();
        in_instr = mk(4'h1, 3'd5, 3'd3, 3'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL raw_stall[%0d] got %b exp %b", i, in_ready, 1'b0);
            end
            tick();
        end
        wb_en = 1'b1; wb_rd = 3'd3; wb_data = 8'h08;
        #1;
`ifdef WB_BYPASS_EN
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_bypass_ready got %b exp %b", in_ready, 1'b1);
        end
        tick();
        wb_en = 1'b0;
`else
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_wb_cycle_ready got %b exp %b", in_ready, 1'b0);
        end
        tick();
        wb_en = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_after_wb_ready got %b exp %b", in_ready, 1'b1);
        end
        tick();
`endif
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h1, 8'h08, 8'h05, 3'd5}) begin
            miscompares++;
            $display("FAIL raw_slot got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h1, 8'h08, 8'h05, 3'd5});
        end
    endtask

    task automatic test_backpressure();
        in_instr = mk(4'h2, 3'd6, 3'd1, 3'd2);
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h2, 8'h05, 8'h03, 3'd6}) begin
            miscompares++;
            $display("FAIL bp_load got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h2, 8'h05, 8'h03, 3'd6});
        end
        in_instr = mk(4'h3, 3'd7, 3'd1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready[%0d] got %b exp %b", i, in_ready, 1'b0);
            end
            tick();
            vectors++;
            if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h2, 8'h05, 8'h03, 3'd6}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got %h exp %h", i, {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h2, 8'h05, 8'h03, 3'd6});
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h3, 8'h05, 8'h03, 3'd7}) begin
            miscompares++;
            $display("FAIL bp_release got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h3, 8'h05, 8'h03, 3'd7});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [3];
        logic [23:0] exp [3];
        seq = '{mk(4'h4, 3'd0, 3'd1, 3'd2), mk(4'h5, 3'd0, 3'd2, 3'd1), mk(4'h6, 3'd0, 3'd1, 3'd1)};
        exp = '{{1'b1, 4'h4, 8'h05, 8'h03, 3'd0}, {1'b1, 4'h5, 8'h03, 8'h05, 3'd0}, {1'b1, 4'h6, 8'h05, 8'h05, 3'd0}};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = seq[i];
            tick();
            vectors++;
            if ({out_valid, out_opcode, out_a, out_b, out_rd} !== exp[i]) begin
                miscompares++;
                $display("FAIL b2b[%0d] got %h exp %h", i, {out_valid, out_opcode, out_a, out_b, out_rd}, exp[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        // rs1 field names busy r4, which an illegal op must not wait on
        in_instr = {4'b1011, 3'd1, 3'd4, 3'd5, 3'd0};
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_ready got %b exp %b", in_ready, 1'b1);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({illegal, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL ill_pulse got %b exp %b", {illegal, out_valid}, 2'b10);
        end
        tick();
        vectors++;
        if ({illegal, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL ill_one_cycle got %b exp %b", {illegal, out_valid}, 2'b00);
        end
        in_instr = mk(4'h0, 3'd0, 3'd1, 3'd1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_no_busy_set got %b exp %b", in_ready, 1'b1);
        end
        in_instr = mk(4'h0, 3'd0, 3'd4, 3'd0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_busy_kept got %b exp %b", in_ready, 1'b0);
        end
    endtask

    task automatic test_flush();
        wb_en = 1'b1; wb_rd = 3'd6; wb_data = 8'h11;
        tick();
        wb_en = 1'b0;
        out_ready = 1'b0;
        in_instr = mk(4'h0, 3'd6, 3'd1, 3'd2);
        in_valid = 1'b1;
        tick();
        vectors++;
        if ({out_valid, out_rd} !== {1'b1, 3'd6}) begin
            miscompares++;
            $display("FAIL flush_load got %h exp %h", {out_valid, out_rd}, {1'b1, 3'd6});
        end
        in_instr = mk(4'h4, 3'd0, 3'd6, 3'd1);
        flush = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle_ready got %b exp %b", in_ready, 1'b0);
        end
        tick();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_valid got %b exp %b", out_valid, 1'b0);
        end
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_busy_cleared got %b exp %b", in_ready, 1'b1);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {1'b1, 4'h4, 8'h11, 8'h05, 3'd0}) begin
            miscompares++;
            $display("FAIL flush_reissue got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd}, {1'b1, 4'h4, 8'h11, 8'h05, 3'd0});
        end
    endtask

    task automatic test_reset_mid_stall();
        in_instr = mk(4'h1, 3'd0, 3'd4, 3'd5);
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pre_stall got %b exp %b", in_ready, 1'b0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd, illegal, in_ready} !== {25'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_async got %h exp %h", {out_valid, out_opcode, out_a, out_b, out_rd, illegal, in_ready}, {25'd0, 1'b1});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_instr = mk(4'h0, 3'd7, 3'd4, 3'd5);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_busy_clear got %b exp %b", in_ready, 1'b1);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_issue got %b exp %b", out_valid, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [7:0] m_rf [8];
        logic [7:0] val [8];
        bit         m_busy [8];
        bit         pend [8];
        logic       m_valid, m_ill;
        logic [3:0] m_op;
        logic [7:0] m_a, m_b;
        logic [2:0] m_rd;
        int         op, rd, r1, r2, start, idx;
        bit         legal, alu, hz, exp_rdy, acc, found;

        rst_n = 1'b0;
        idle();
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 8; s++) begin
            m_rf[s]   = 8'h00;
            m_busy[s] = 1'b0;
        end
        m_valid = 1'b0; m_ill = 1'b0; m_op = 4'h0; m_a = 8'h00; m_b = 8'h00; m_rd = 3'd0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            vectors++;
            if ({out_valid, out_opcode, out_a, out_b, out_rd} !== {m_valid, m_op, m_a, m_b, m_rd}) begin
                miscompares++;
                $display("FAIL rand_slot cyc %0d got %h exp %h", cyc, {out_valid, out_opcode, out_a, out_b, out_rd}, {m_valid, m_op, m_a, m_b, m_rd});
            end
            vectors++;
            if (illegal !== m_ill) begin
                miscompares++;
                $display("FAIL rand_illegal cyc %0d got %b exp %b", cyc, illegal, m_ill);
            end

            in_instr = 16'($urandom);
            in_instr[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = 1'b0;
            wb_rd     = 3'd0;
            wb_data   = 8'($urandom);
            // writebacks only ever retire an outstanding producer
            if ($urandom_range(0, 2) == 0) begin
                start = $urandom_range(0, 7);
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    idx = (start + k) % 8;
                    if (!found && m_busy[idx]) begin
                        found = 1'b1;
                        wb_en = 1'b1;
                        wb_rd = 3'(idx);
                    end
                end
            end
            #1;

            op = int'(in_instr[15:12]);
            rd = int'(in_instr[11:9]);
            r1 = int'(in_instr[8:6]);
            r2 = int'(in_instr[5:3]);
            legal = (op <= 8);
            alu   = (op < 8);
            for (int s = 0; s < 8; s++) begin
                pend[s] = m_busy[s] && !(BYP && wb_en && (int'(wb_rd) == s));
                val[s]  = (s == 0) ? 8'h00 : ((BYP && wb_en && (int'(wb_rd) == s)) ? wb_data : m_rf[s]);
            end
            hz = legal && ((alu && (pend[r1] || pend[r2])) || pend[rd]);
            exp_rdy = !flush && (!m_valid || out_ready) && !hz;
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, in_ready, exp_rdy);
            end
            acc = in_valid && exp_rdy;

            if (wb_en) m_busy[wb_rd] = 1'b0;
            if (flush && m_valid) m_busy[m_rd] = 1'b0;
            if (acc && legal && rd != 0) m_busy[rd] = 1'b1;
            if (wb_en && wb_rd != 3'd0) m_rf[wb_rd] = wb_data;
            m_ill = acc && !legal;
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc && legal) begin
                m_valid = 1'b1;
                m_op    = alu ? 4'(op) : 4'h0;
                m_a     = alu ? val[r1] : 8'h00;
                m_b     = alu ? val[r2] : in_instr[7:0];
                m_rd    = 3'(rd);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_add_li();
        test_raw();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
